// File: rtl/sdar_core.sv
// sdar_core: AXI4-Stream stage that replaces the first UDP payload word of matching IPv4/UDP packets
// with its integer square root; AXI-Lite exposes signature, match port and packet counters.

module sdar_sqrt (
  input  logic        cf_clk,
  input  logic        rst_n,
  input  logic        start_en,
  input  logic [31:0] input_r,
  output logic        cf_done,
  output logic [31:0] cf_return_value
);
  localparam int unsigned ITERS = 16;

  logic [31:0] r_rad;
  logic [17:0] r_rem;
  logic [15:0] r_root;
  logic [4:0]  r_cnt;
  logic [19:0] w_rem_sh;
  logic [19:0] w_trial;
  logic [19:0] w_rem_nxt;
  logic [15:0] w_root_nxt;
  logic        w_unused;

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  always_comb begin
    w_rem_sh   = {r_rem, r_rad[31:30]};
    w_trial    = {2'b00, r_root, 2'b01};
    w_rem_nxt  = w_rem_sh;
    w_root_nxt = {r_root[14:0], 1'b0};
    if (w_rem_sh >= w_trial) begin
      w_rem_nxt  = w_rem_sh - w_trial;
      w_root_nxt = {r_root[14:0], 1'b1};
    end
  end

  // Remainder never exceeds 2*root, so the top two bits of the step result are always zero.
  assign w_unused = ^w_rem_nxt[19:18];

  always_ff @(posedge cf_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad           <= '0;
      r_rem           <= '0;
      r_root          <= '0;
      r_cnt           <= '0;
      cf_done         <= 1'b0;
      cf_return_value <= '0;
    end else begin
      cf_done <= 1'b0;
      if (start_en) begin
        r_rad  <= input_r;
        r_rem  <= '0;
        r_root <= '0;
        r_cnt  <= 5'(ITERS);
      end else if (r_cnt != 5'd0) begin
        r_rad  <= {r_rad[29:0], 2'b00};
        r_rem  <= w_rem_nxt[17:0];
        r_root <= w_root_nxt;
        r_cnt  <= r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          cf_done         <= 1'b1;
          cf_return_value <= {16'h0000, w_root_nxt};
        end
      end
    end
  end
endmodule

module sdar_core #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXI_ADDR_WIDTH   = 12,
  parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
  parameter logic [15:0] UDP_PORT_DEFAULT     = 16'd10000
) (
  input  logic                                axis_aclk,
  input  logic                                axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  input  logic                                S_AXI_ACLK,
  input  logic                                S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic                                S_AXI_AWVALID,
  output logic                                S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
  input  logic                                S_AXI_WVALID,
  output logic                                S_AXI_WREADY,
  input  logic                                S_AXI_BREADY,
  output logic [1:0]                          S_AXI_BRESP,
  output logic                                S_AXI_BVALID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic                                S_AXI_ARVALID,
  output logic                                S_AXI_ARREADY,
  input  logic                                S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
  output logic [1:0]                          S_AXI_RRESP,
  output logic                                S_AXI_RVALID
);
  localparam logic [31:0] SIGNATURE = 32'h53444152;

  typedef enum logic [1:0] {ST_HDR0, ST_HDR1, ST_BODY, ST_WAIT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_hdr_ok;
  logic [15:0]   r_port;
  logic [31:0]   r_match_cnt;
  logic [31:0]   r_total_cnt;
  logic [255:0]  r_hold_data;
  logic [31:0]   r_hold_keep;
  logic [127:0]  r_hold_user;
  logic          r_hold_last;
  logic          r_res_rdy;

  logic          w_out_free;
  logic          w_in_fire;
  logic          w_hdr_ok;
  logic          w_match;
  logic [15:0]   w_dport;
  logic          w_hdr_cap;
  logic          w_fwd;
  logic          w_take;
  logic          w_emit;
  logic          w_aw_fire;
  logic          w_ar_fire;
  logic [31:0]   w_rdata;
  logic          w_unused;

  logic          cf_clk;
  logic          user_value_valid;
  logic [31:0]   user_value;
  logic          start_en;
  logic [31:0]   input_r;
  logic          cf_done;
  logic [31:0]   cf_return_value;
  logic          return_value_valid;
  logic [31:0]   return_value;

  assign cf_clk   = axis_aclk;
  assign start_en = user_value_valid;
  assign input_r  = user_value;

  assign w_out_free    = !m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = w_out_free & (r_state != ST_WAIT);
  assign w_in_fire     = s_axis_tvalid & s_axis_tready;

  // Ethertype 0x0800, IPv4 with IHL 5, protocol UDP; port compared in network byte order.
  assign w_hdr_ok = (s_axis_tdata[111:96] == 16'h0008) && (s_axis_tdata[119:112] == 8'h45) &&
                    (s_axis_tdata[191:184] == 8'd17);
  assign w_dport  = {s_axis_tdata[39:32], s_axis_tdata[47:40]};
  assign w_match  = r_hdr_ok && (w_dport == r_port) && (s_axis_tkeep[13:10] == 4'hF);

  assign w_unused = ^{S_AXI_ACLK, S_AXI_ARESETN, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                      S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2]};

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) r_state <= ST_HDR0;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_cap   = 1'b0;
    w_fwd       = 1'b0;
    w_take      = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      ST_HDR0: if (w_in_fire) begin
        w_hdr_cap   = 1'b1;
        w_fwd       = 1'b1;
        w_state_nxt = s_axis_tlast ? ST_HDR0 : ST_HDR1;
      end
      ST_HDR1: if (w_in_fire) begin
        if (w_match) begin
          w_take      = 1'b1;
          w_state_nxt = ST_WAIT;
        end else begin
          w_fwd       = 1'b1;
          w_state_nxt = s_axis_tlast ? ST_HDR0 : ST_BODY;
        end
      end
      ST_BODY: if (w_in_fire) begin
        w_fwd = 1'b1;
        if (s_axis_tlast) w_state_nxt = ST_HDR0;
      end
      ST_WAIT: if (r_res_rdy && w_out_free) begin
        w_emit      = 1'b1;
        w_state_nxt = r_hold_last ? ST_HDR0 : ST_BODY;
      end
      default: w_state_nxt = ST_HDR0;
    endcase
  end

  sdar_sqrt u_sqrt (
    .cf_clk          (cf_clk),
    .rst_n           (axis_resetn),
    .start_en        (start_en),
    .input_r         (input_r),
    .cf_done         (cf_done),
    .cf_return_value (cf_return_value)
  );

  // Output register stage, held beat and compute hand-off.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      m_axis_tvalid      <= 1'b0;
      m_axis_tdata       <= '0;
      m_axis_tkeep       <= '0;
      m_axis_tuser       <= '0;
      m_axis_tlast       <= 1'b0;
      r_hdr_ok           <= 1'b0;
      r_hold_data        <= '0;
      r_hold_keep        <= '0;
      r_hold_user        <= '0;
      r_hold_last        <= 1'b0;
      r_res_rdy          <= 1'b0;
      user_value_valid   <= 1'b0;
      user_value         <= '0;
      return_value_valid <= 1'b0;
      return_value       <= '0;
      r_match_cnt        <= '0;
      r_total_cnt        <= '0;
    end else begin
      user_value_valid   <= 1'b0;
      return_value_valid <= cf_done;
      if (cf_done) return_value <= cf_return_value;
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        if (m_axis_tlast) r_total_cnt <= r_total_cnt + 32'd1;
      end
      if (w_hdr_cap) r_hdr_ok <= w_hdr_ok;
      if (w_fwd) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tkeep  <= s_axis_tkeep;
        m_axis_tuser  <= s_axis_tuser;
        m_axis_tlast  <= s_axis_tlast;
      end else if (w_emit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= r_hold_data;
        m_axis_tkeep  <= r_hold_keep;
        m_axis_tuser  <= r_hold_user;
        m_axis_tlast  <= r_hold_last;
      end
      if (w_take) begin
        r_hold_data      <= s_axis_tdata;
        r_hold_keep      <= s_axis_tkeep;
        r_hold_user      <= s_axis_tuser;
        r_hold_last      <= s_axis_tlast;
        r_res_rdy        <= 1'b0;
        user_value_valid <= 1'b1;
        user_value       <= {s_axis_tdata[87:80], s_axis_tdata[95:88],
                             s_axis_tdata[103:96], s_axis_tdata[111:104]};
        r_match_cnt      <= r_match_cnt + 32'd1;
      end
      // Result goes back big-endian into payload bytes 42-45; UDP checksum cleared.
      if (return_value_valid) begin
        r_hold_data[111:80] <= {return_value[7:0], return_value[15:8],
                                return_value[23:16], return_value[31:24]};
        r_hold_data[79:64]  <= 16'h0000;
        r_res_rdy           <= 1'b1;
      end
      if (w_emit) r_res_rdy <= 1'b0;
    end
  end

  assign w_aw_fire   = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_ar_fire   = S_AXI_ARREADY & S_AXI_ARVALID;
  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  always_comb begin
    w_rdata = '0;
    case (S_AXI_ARADDR[11:2])
      10'h000: w_rdata = SIGNATURE;
      10'h001: w_rdata = {16'h0000, r_port};
      10'h002: w_rdata = r_match_cnt;
      10'h003: w_rdata = r_total_cnt;
      default: w_rdata = '0;
    endcase
  end

  // AXI-Lite slave: AW and W accepted in the same cycle, one outstanding transaction per direction.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      r_port        <= UDP_PORT_DEFAULT;
    end else begin
      S_AXI_AWREADY <= !S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID & !S_AXI_BVALID;
      S_AXI_WREADY  <= !S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID & !S_AXI_BVALID;
      if (w_aw_fire) begin
        S_AXI_BVALID <= 1'b1;
        if (S_AXI_AWADDR[11:2] == 10'h001) begin
          if (S_AXI_WSTRB[0]) r_port[7:0]  <= S_AXI_WDATA[7:0];
          if (S_AXI_WSTRB[1]) r_port[15:8] <= S_AXI_WDATA[15:8];
        end
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
      S_AXI_ARREADY <= !S_AXI_ARREADY & S_AXI_ARVALID & !S_AXI_RVALID;
      if (w_ar_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= w_rdata;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sdar_core.sv
// Randomized bench for sdar_core: byte-level packet model with integer sqrt rewrite, AXI-Lite checks.
`timescale 1ns/1ps
module tb_sdar_core;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [255:0] s_tdata = '0;
  logic [31:0]  s_tkeep = '0;
  logic [127:0] s_tuser = '0;
  logic         s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic [127:0] m_tuser;
  logic         m_tvalid, m_tlast;
  logic         m_tready = 1'b1;
  logic [11:0]  awaddr = '0, araddr = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;

  always #5 clk = ~clk;

  sdar_core dut (
    .axis_aclk(clk), .axis_resetn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid)
  );

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t       in_q[$];
  beat_t       exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_start = 0;
  int          exp_match = 0;
  int          exp_total = 0;
  logic [15:0] model_port = 16'd10000;
  logic        bp_en = 1'b0;
  logic [7:0]  pb[0:255];
  logic [7:0]  ob[0:255];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint x);
    longint r;
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // kind 0: IPv4/UDP header, 1: IPv6 ethertype, 2: random bytes. Model works on packet bytes.
  task automatic make_pkt(input int kind, input int len, input logic [15:0] dport, input logic [31:0] pay);
    int nb;
    logic is_m;
    longint r;
    beat_t bi, bo;
    nb = (len + 31) / 32;
    for (int i = 0; i < 256; i++) pb[i] = 8'($urandom);
    if (kind != 2) begin
      pb[12] = (kind == 1) ? 8'h86 : 8'h08;
      pb[13] = (kind == 1) ? 8'hDD : 8'h00;
      pb[14] = 8'h45;
      pb[23] = 8'd17;
      pb[36] = dport[15:8];
      pb[37] = dport[7:0];
      for (int i = 0; i < 4; i++) pb[42 + i] = pay[31 - 8 * i -: 8];
    end
    for (int i = 0; i < 256; i++) ob[i] = pb[i];
    is_m = (len >= 46) && pb[12] == 8'h08 && pb[13] == 8'h00 && pb[14] == 8'h45 &&
           pb[23] == 8'd17 && {pb[36], pb[37]} == model_port;
    if (is_m) begin
      r = isqrt(longint'({pb[42], pb[43], pb[44], pb[45]}));
      ob[40] = 8'h00;
      ob[41] = 8'h00;
      for (int i = 0; i < 4; i++) ob[42 + i] = 8'(r >> (24 - 8 * i));
      exp_match++;
    end
    exp_total++;
    for (int b = 0; b < nb; b++) begin
      bi.u = {$urandom, $urandom, $urandom, $urandom};
      bi.l = (b == nb - 1);
      for (int j = 0; j < 32; j++) begin
        bi.d[j*8 +: 8] = pb[b*32 + j];
        bo.d[j*8 +: 8] = ob[b*32 + j];
        bi.k[j] = (b * 32 + j < len);
      end
      bo.k = bi.k;
      bo.u = bi.u;
      bo.l = bi.l;
      in_q.push_back(bi);
      exp_q.push_back(bo);
    end
  endtask

  task automatic send_pkt();
    beat_t b;
    int g;
    @(posedge clk); #1;
    while (in_q.size() > 0) begin
      if (bp_en && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      b = in_q.pop_front();
      s_tvalid = 1'b1; s_tdata = b.d; s_tkeep = b.k; s_tuser = b.u; s_tlast = b.l;
      g = 0;
      forever begin
        @(negedge clk);
        if (s_tready || g > 2000) break;
        g++;
      end
      if (!s_tready) begin
        chk("drv_timeout", 1, 0);
        in_q.delete();
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic pkt(input int kind, input int len, input logic [15:0] dport, input logic [31:0] pay);
    make_pkt(kind, len, dport, pay);
    send_pkt();
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 5000) begin @(negedge clk); g++; end
    repeat (3) @(negedge clk);
    chk("drain", 256'(exp_q.size()), 0);
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    int g = 0;
    @(posedge clk); #1;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    do begin @(negedge clk); g++; end while (!awready && g < 100);
    chk("aw_hs", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    g = 0;
    while (!bvalid && g < 100) begin @(negedge clk); g++; end
    chk("bresp", {bvalid, bresp}, 3'b100);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
    int g = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    do begin @(negedge clk); g++; end while (!arready && g < 100);
    @(posedge clk); #1;
    arvalid = 1'b0;
    g = 0;
    while (!rvalid && g < 100) begin @(negedge clk); g++; end
    d = rdata;
    chk("rresp", {rvalid, rresp}, 3'b100);
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  // Output scoreboard: a beat is taken when valid and ready are both high ahead of the next edge.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rstn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("tdata", m_tdata, e.d);
        chk("tside", {m_tkeep, m_tuser, m_tlast}, {e.k, e.u, e.l});
      end
    end
  end

  // Compute latency and input stall while the compute unit runs.
  initial forever begin
    int cyc;
    logic rdy_seen;
    @(negedge clk);
    if (dut.start_en) begin
      n_start++;
      cyc = 0;
      rdy_seen = 1'b0;
      do begin
        @(negedge clk);
        cyc++;
        if (s_tready) rdy_seen = 1'b1;
      end while (!dut.cf_done && cyc < 40);
      chk("cf_latency", 256'(cyc), 17);
      chk("tready_wait", rdy_seen, 0);
    end
  end

  initial m_tready_drive: forever begin
    @(posedge clk); #1;
    m_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int kind, len;
    logic [15:0] dp;
    repeat (3) @(negedge clk);
    chk("rst_out", {m_tvalid, awready, wready, bvalid, arready, rvalid}, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_tready", s_tready, 1);

    axi_read(12'h000, rd); chk("sig", rd, 32'h53444152);
    axi_read(12'h004, rd); chk("port_rst", rd, 32'd10000);
    axi_read(12'h010, rd); chk("unmapped", rd, 0);
    axi_read(12'h008, rd); chk("match_rst", rd, 0);

    pkt(0, 64, 16'd10000, 32'h00000010);
    pkt(0, 80, 16'd10000, 32'h000F4240);
    pkt(0, 100, 16'd10000, 32'hFFFFFFFF);
    pkt(1, 90, 16'd10000, 32'h00000010);
    pkt(0, 70, 16'd53, 32'h00000010);
    pkt(0, 48, 16'd10000, 32'h00000051);
    pkt(0, 20, 16'd10000, 32'h00000010);
    wait_drain();
    axi_read(12'h008, rd); chk("match_dir", rd, 32'(exp_match));

    axi_write(12'h004, 32'h00001234);
    model_port = 16'h1234;
    axi_read(12'h004, rd); chk("port_wr", rd, 32'h1234);
    axi_write(12'h020, 32'hDEADBEEF);
    axi_read(12'h020, rd); chk("unmapped_wr", rd, 0);
    pkt(0, 64, 16'h1234, 32'h00000400);
    pkt(0, 64, 16'd10000, 32'h00000400);
    wait_drain();

    bp_en = 1'b1;
    for (int p = 0; p < 100; p++) begin
      kind = $urandom_range(0, 4);
      if (kind > 2) kind = 0;
      len  = $urandom_range(14, 150);
      dp   = ($urandom_range(0, 1) == 1) ? 16'h1234 : 16'($urandom);
      make_pkt(kind, len, dp, $urandom);
      send_pkt();
    end
    wait_drain();
    bp_en = 1'b0;
    @(posedge clk); #1;

    axi_read(12'h008, rd); chk("match_cnt", rd, 32'(exp_match));
    axi_read(12'h00C, rd); chk("total_cnt", rd, 32'(exp_total));
    chk("start_cnt", 256'(n_start), 256'(exp_match));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
